// File: rtl/fu_mul_pipe.sv
// fu_mul_pipe: pipelined RV32M multiply FU (MUL/MULH/MULHSU/MULHU) with CDB back-pressure.
// Defining MUL_FLUSH_EN adds a flush port that kills every in-flight uop.
module fu_mul_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 3,
    parameter int ROB_IDX_W  = 5,
    parameter int PRF_IDX_W  = 6,
    parameter int ARF_IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef MUL_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  prv_valid,
    output logic                  prv_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1_value,
    input  logic [DATA_WIDTH-1:0] rs2_value,
    input  logic [ROB_IDX_W-1:0]  rob_id,
    input  logic [PRF_IDX_W-1:0]  rd_phy,
    input  logic [ARF_IDX_W-1:0]  rd_arch,
    output logic                  nxt_valid,
    input  logic                  nxt_ready,
    output logic [DATA_WIDTH-1:0] cdb_value,
    output logic [ROB_IDX_W-1:0]  cdb_rob_id,
    output logic [PRF_IDX_W-1:0]  cdb_rd_phy,
    output logic [ARF_IDX_W-1:0]  cdb_rd_arch
);
    localparam int W  = DATA_WIDTH;
    localparam int H  = W / 2;
    localparam int TW = ROB_IDX_W + PRF_IDX_W + ARF_IDX_W;
    localparam int D  = STAGES - 2;

    logic            kill, en, v1, v2, out_v;
    logic [1:0]      op1, op2, out_op;
    logic [TW-1:0]   tag1, tag2, out_tag;
    logic [W:0]      a1, b1;
    logic [W+1:0]    al, ah, bl, bh, ll2, lh2, hl2, hh2;
    logic [2*W-1:0]  sum2, out_p;

    function automatic logic [2*W-1:0] sx(input logic [W+1:0] x);
        return {{(W-2){x[W+1]}}, x};
    endfunction

`ifdef MUL_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif
    assign en        = ~out_v | nxt_ready;
    assign prv_ready = en & ~kill;
    assign nxt_valid = out_v & ~kill;

    // Halves are W+2 wide so the modular products equal the exact signed partials
    assign al   = {{(H+2){1'b0}}, a1[H-1:0]};
    assign ah   = {{(H+1){a1[W]}}, a1[W:H]};
    assign bl   = {{(H+2){1'b0}}, b1[H-1:0]};
    assign bh   = {{(H+1){b1[W]}}, b1[W:H]};
    assign sum2 = (sx(hh2) << W) + ((sx(lh2) + sx(hl2)) << H) + sx(ll2);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {v1, v2} <= '0;
        else if (kill) {v1, v2} <= '0;
        else if (en) {v1, v2} <= {prv_valid, v1};

    always_ff @(posedge clk)
        if (en) begin
            op1  <= op;
            tag1 <= {rob_id, rd_phy, rd_arch};
            a1   <= {rs1_value[W-1] & (op != 2'd3), rs1_value};
            b1   <= {rs2_value[W-1] & ~op[1], rs2_value};
            op2  <= op1;
            tag2 <= tag1;
            ll2  <= al * bl;
            lh2  <= al * bh;
            hl2  <= ah * bl;
            hh2  <= ah * bh;
        end

    generate
        if (D > 0) begin : g_dly
            logic [D-1:0]   dv;
            logic [1:0]     dop  [D];
            logic [TW-1:0]  dtag [D];
            logic [2*W-1:0] dp   [D];
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) dv <= '0;
                else if (kill) dv <= '0;
                else if (en) dv <= D'({dv, v2});
            always_ff @(posedge clk)
                if (en) begin
                    dop[0]  <= op2;
                    dtag[0] <= tag2;
                    dp[0]   <= sum2;
                    for (int i = 1; i < D; i++) begin
                        dop[i]  <= dop[i-1];
                        dtag[i] <= dtag[i-1];
                        dp[i]   <= dp[i-1];
                    end
                end
            assign out_v   = dv[D-1];
            assign out_op  = dop[D-1];
            assign out_tag = dtag[D-1];
            assign out_p   = dp[D-1];
        end else begin : g_nodly
            assign out_v   = v2;
            assign out_op  = op2;
            assign out_tag = tag2;
            assign out_p   = sum2;
        end
    endgenerate

    assign cdb_value = out_op == 2'd0 ? out_p[W-1:0] : out_p[2*W-1:W];
    assign {cdb_rob_id, cdb_rd_phy, cdb_rd_arch} = out_tag;
endmodule
